pipelined_cla_adder: RTL and testbench

PIPELINED_CLA_ADDER -- requirements
Module: pipelined_cla_adder

---
 rtl/pipelined_cla_adder_if.sv | 28 ++
 rtl/pipelined_cla_adder.sv | 95 +++++++++
 tb/tb_pipelined_cla_adder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// Operand/result handshake bundle for the pipelined CLA adder.
// master drives operands and out_ready; slave is the adder.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             zero;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output a, b, cin, sub, in_valid, out_ready,
    input  in_ready, s, cout, ovf, zero, out_valid
  );

  modport slave (
    input  a, b, cin, sub, in_valid, out_ready,
    output in_ready, s, cout, ovf, zero, out_valid
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Add/subtract pipeline: one 4-bit lookahead group per stage,
// carry and partial sum handed stage to stage.
module pipelined_cla_adder #(
  parameter int  WIDTH = 16,
  localparam int NG    = WIDTH / 4
) (
  input logic clk,
  input logic reset_n,
  pipelined_cla_adder_if.slave io
);

  typedef struct packed {
    logic             v;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             c;
    logic             ov;
  } stg_t;

  stg_t       src [NG];
  stg_t       nxt [NG];
  stg_t       q   [NG];
  logic [5:0] res [NG];
  logic       adv;

  // returns {carry_into_msb ^ carry_out, carry_out, sum[3:0]}
  function automatic logic [5:0] cla4(
    input logic [3:0] x,
    input logic [3:0] y,
    input logic       ci
  );
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = x & y;
    p    = x ^ y;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0])
         | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1])
         | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & ci);
    c[4] = g[3] | (p[3] & g[2])
         | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    return {c[4] ^ c[3], c[4], p ^ c[3:0]};
  endfunction

  assign adv = !q[NG-1].v || io.out_ready;

  always_comb begin
    for (int k = 0; k < NG; k++) begin
      if (k == 0) begin
        src[k].v  = io.in_valid && adv;
        src[k].a  = io.a;
        src[k].b  = io.sub ? ~io.b : io.b;
        src[k].s  = '0;
        src[k].c  = io.sub | io.cin;
        src[k].ov = 1'b0;
      end else begin
        src[k] = q[(k == 0) ? 0 : k - 1];
      end
      res[k] = cla4(src[k].a[4*k +: 4],
                    src[k].b[4*k +: 4],
                    src[k].c);
      nxt[k]             = src[k];
      nxt[k].s[4*k +: 4] = res[k][3:0];
      nxt[k].c           = res[k][4];
      nxt[k].ov          = res[k][5];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NG; k++) begin
        q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NG; k++) begin
        q[k] <= nxt[k];
      end
    end
  end

  assign io.in_ready  = adv;
  assign io.out_valid = q[NG-1].v;
  assign io.s         = q[NG-1].s;
  assign io.cout      = q[NG-1].c;
  assign io.ovf       = q[NG-1].ov;
  assign io.zero      = (q[NG-1].s == '0);

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed-vector bench for pipelined_cla_adder (WIDTH 16).
// Scoreboard of vector indices follows accepted operands.
module tb_pipelined_cla_adder;

  localparam int W = 16;
  localparam int NV = 12;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vt [NV];
  int   checks;
  int   failures;
  int   expq [$];
  int   cur_idx;

  logic clk;
  logic reset_n;

  pipelined_cla_adder_if #(.WIDTH(W)) io ();

  pipelined_cla_adder #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .io      (io)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h",
               nm, act, exp);
    end
  endtask

  task automatic drive(int i);
    io.a        = vt[i].a;
    io.b        = vt[i].b;
    io.cin      = vt[i].cin;
    io.sub      = vt[i].sub;
    io.in_valid = 1'b1;
    cur_idx     = i;
  endtask

  task automatic idle();
    io.a        = '0;
    io.b        = '0;
    io.cin      = 1'b0;
    io.sub      = 1'b0;
    io.in_valid = 1'b0;
  endtask

  // account for both handshakes just before the edge
  task automatic cycle();
    if (io.out_valid && io.out_ready) begin
      if (expq.size() == 0) begin
        chk("spurious_result", 32'd1, 32'd0);
      end else begin
        int i;
        i = expq.pop_front();
        chk($sformatf("s[%0d]", i), 32'(io.s), 32'(vt[i].s));
        chk($sformatf("cout[%0d]", i), 32'(io.cout),
            32'(vt[i].cout));
        chk($sformatf("ovf[%0d]", i), 32'(io.ovf),
            32'(vt[i].ovf));
        chk($sformatf("zero[%0d]", i), 32'(io.zero),
            32'(vt[i].zero));
      end
    end
    if (io.in_valid && io.in_ready) expq.push_back(cur_idx);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(string nm);
    int n;
    n = 0;
    idle();
    io.out_ready = 1'b1;
    while (expq.size() > 0 && n < 40) begin
      cycle();
      n++;
    end
    chk(nm, 32'(expq.size()), 32'd0);
    expq.delete();
  endtask

  initial begin
    int p;
    int lat;
    int first;
    int last;
    int nv;
    int nbad;
    int stall_left;
    bit stalled;
    logic [W-1:0] held_s;
    logic acc;

    checks   = 0;
    failures = 0;
    cur_idx  = 0;

    vt[0]  = '{16'h1234, 16'h4321, 0, 0, 16'h5555, 0, 0, 0};
    vt[1]  = '{16'h7FFF, 16'h0001, 0, 0, 16'h8000, 0, 1, 0};
    vt[2]  = '{16'hFFFF, 16'h0001, 0, 0, 16'h0000, 1, 0, 1};
    vt[3]  = '{16'h0005, 16'h0007, 0, 1, 16'hFFFE, 0, 0, 0};
    vt[4]  = '{16'h8000, 16'h8000, 0, 1, 16'h0000, 1, 0, 1};
    vt[5]  = '{16'h0000, 16'h0000, 1, 0, 16'h0001, 0, 0, 0};
    vt[6]  = '{16'h8000, 16'h8000, 0, 0, 16'h0000, 1, 1, 1};
    vt[7]  = '{16'hFFFF, 16'hFFFF, 1, 0, 16'hFFFF, 1, 0, 0};
    vt[8]  = '{16'h0F0F, 16'h00F1, 0, 0, 16'h1000, 0, 0, 0};
    vt[9]  = '{16'h1000, 16'h0001, 0, 1, 16'h0FFF, 1, 0, 0};
    vt[10] = '{16'h8000, 16'h0001, 0, 1, 16'h7FFF, 1, 1, 0};
    vt[11] = '{16'h0003, 16'h0003, 1, 1, 16'h0000, 1, 0, 1};

    // reset state, asserted between edges
    idle();
    io.out_ready = 1'b1;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(io.out_valid), 32'd0);
    chk("rst_in_ready", 32'(io.in_ready), 32'd1);
    chk("rst_s", 32'(io.s), 32'd0);
    chk("rst_cout", 32'(io.cout), 32'd0);
    chk("rst_ovf", 32'(io.ovf), 32'd0);
    chk("rst_zero", 32'(io.zero), 32'd1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single-op latency
    drive(0);
    cycle();
    idle();
    lat = 1;
    while (!io.out_valid && lat < 10) begin
      cycle();
      lat++;
    end
    chk("latency", 32'(lat), 32'd4);
    drain("latency_drain");

    // back-to-back stream
    p = 0; first = -1; last = -1; nv = 0; nbad = 0;
    for (int c = 0; c < 40 && (p < NV || expq.size() > 0);
         c++) begin
      if (p < NV) drive(p);
      else idle();
      if (io.out_valid) begin
        if (first < 0) first = c;
        last = c;
        nv++;
      end
      if (!io.in_ready) nbad++;
      acc = io.in_valid && io.in_ready;
      cycle();
      if (acc) p++;
    end
    chk("stream_accepted", 32'(p), NV);
    chk("stream_out_count", 32'(nv), NV);
    chk("stream_contiguous", 32'(last - first + 1), NV);
    chk("stream_in_ready", 32'(nbad), 32'd0);
    drain("stream_drain");

    // backpressure: 3-cycle stall on first result
    p = 0; stall_left = 0; stalled = 0; held_s = '0;
    for (int c = 0; c < 40 && (p < 6 || expq.size() > 0);
         c++) begin
      if (p < 6) drive(p);
      else idle();
      if (io.out_valid && !stalled) begin
        stalled    = 1;
        stall_left = 3;
        held_s     = io.s;
      end
      io.out_ready = (stall_left == 0);
      #1;
      if (stall_left > 0) begin
        chk("bp_in_ready", 32'(io.in_ready), 32'd0);
        chk("bp_out_valid", 32'(io.out_valid), 32'd1);
        chk("bp_s_hold", 32'(io.s), 32'(held_s));
        stall_left--;
      end
      acc = io.in_valid && io.in_ready;
      cycle();
      if (acc) p++;
    end
    chk("bp_stalled", 32'(stalled), 32'd1);
    chk("bp_accepted", 32'(p), 32'd6);
    drain("bp_drain");

    // reset with three results in flight
    io.out_ready = 1'b1;
    for (int i = 3; i < 6; i++) begin
      drive(i);
      cycle();
    end
    idle();
    reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(io.out_valid), 32'd0);
    chk("midrst_in_ready", 32'(io.in_ready), 32'd1);
    chk("midrst_zero", 32'(io.zero), 32'd1);
    expq.delete();
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive(7);
    cycle();
    idle();
    nv = 0;
    for (int c = 0; c < 10; c++) begin
      if (io.out_valid) nv++;
      cycle();
    end
    chk("post_rst_results", 32'(nv), 32'd1);
    chk("post_rst_pending", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
